// File: rtl/spike_pattern_sequencer_if.sv
// Host memory window and timestep stream of the spike pattern sequencer.
// master = host/downstream side, slave = sequencer.
interface spike_pattern_sequencer_if #(
    parameter int NUM_INPUTS         = 9,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_TIMESTEPS_BITS = 8,
    parameter int BATCH_ADDR_WIDTH   = 1
);
    logic                          wr_en;
    logic [BATCH_ADDR_WIDTH-1:0]   wr_batch;
    logic [MAX_TIMESTEPS_BITS-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          rd_en;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          rd_valid;
    logic                          wr_err;
    logic                          start;
    logic                          abort;
    logic                          loop_en;
    logic [MAX_TIMESTEPS_BITS:0]   sim_time;
    logic [NUM_INPUTS-1:0]         spikes;
    logic                          spikes_valid;
    logic                          spikes_ready;
    logic [MAX_TIMESTEPS_BITS-1:0] timestep;
    logic                          busy;
    logic                          done;

    modport master (
        output wr_en, wr_batch, wr_addr, wr_data, rd_en,
        output start, abort, loop_en, sim_time, spikes_ready,
        input  rd_data, rd_valid, wr_err, spikes, spikes_valid, timestep, busy, done
    );

    modport slave (
        input  wr_en, wr_batch, wr_addr, wr_data, rd_en,
        input  start, abort, loop_en, sim_time, spikes_ready,
        output rd_data, rd_valid, wr_err, spikes, spikes_valid, timestep, busy, done
    );
endinterface

// File: rtl/spike_pattern_sequencer.sv
// Per-timestep spike pattern store with host load/readback and valid/ready
// playback to the first network layer, including loop and abort modes.
module spike_pattern_sequencer #(
    parameter int NUM_INPUTS         = 9,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_TIMESTEPS_BITS = 8,
    parameter int BATCH_ADDR_WIDTH   = 1
) (
    input logic clk,
    input logic rst,
    spike_pattern_sequencer_if.slave bus
);
    localparam int NUM_BATCHES   = 2 ** BATCH_ADDR_WIDTH;
    localparam int PATTERN_WIDTH = DATA_WIDTH * NUM_BATCHES;
    localparam int DEPTH         = 2 ** (MAX_TIMESTEPS_BITS + BATCH_ADDR_WIDTH);
    localparam logic [MAX_TIMESTEPS_BITS:0]   MAX_LEN  = {1'b1, {MAX_TIMESTEPS_BITS{1'b0}}};
    localparam logic [MAX_TIMESTEPS_BITS-1:0] TS_ONE   = MAX_TIMESTEPS_BITS'(1);
    localparam logic [BATCH_ADDR_WIDTH-1:0]   BATCH_ONE = BATCH_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t                                  state;
    logic [MAX_TIMESTEPS_BITS-1:0]           ts;
    logic [MAX_TIMESTEPS_BITS-1:0]           last_ts;
    logic [BATCH_ADDR_WIDTH-1:0]             bcnt;
    logic [PATTERN_WIDTH-1:0]                shadow;
    logic [PATTERN_WIDTH-1:0]                assembled;
    logic [DATA_WIDTH-1:0]                   mem [DEPTH];
    logic [MAX_TIMESTEPS_BITS:0]             eff_len;
    logic [MAX_TIMESTEPS_BITS+BATCH_ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0]                   fetch_word;

    assign host_addr  = {bus.wr_addr, bus.wr_batch};
    assign eff_len    = (bus.sim_time > MAX_LEN) ? MAX_LEN : bus.sim_time;
    assign fetch_word = mem[{ts, bcnt}];

    // The RAM's registered read port is the shadow register itself, so the
    // pattern is complete on the edge that issues the last batch read.
    always_comb begin
        assembled = shadow;
        for (int unsigned b = 0; b < NUM_BATCHES; b++) begin
            if (bcnt == BATCH_ADDR_WIDTH'(b))
                assembled[b*DATA_WIDTH +: DATA_WIDTH] = fetch_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en && !bus.busy)
            mem[host_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.wr_err   <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.wr_err   <= 1'b0;
            if (bus.busy) begin
                bus.wr_err <= bus.wr_en | bus.rd_en;
            end else if (bus.rd_en) begin
                bus.rd_data  <= mem[host_addr];
                bus.rd_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ts               <= '0;
            last_ts          <= '0;
            bcnt             <= '0;
            shadow           <= '0;
            bus.spikes       <= '0;
            bus.spikes_valid <= 1'b0;
            bus.timestep     <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ts      <= '0;
                        bcnt    <= '0;
                        last_ts <= eff_len[MAX_TIMESTEPS_BITS-1:0] - TS_ONE;
                        if (eff_len != '0) begin
                            state    <= FETCH;
                            bus.busy <= 1'b1;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (bus.abort) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        shadow <= assembled;
                        bcnt   <= bcnt + BATCH_ONE;
                        if (bcnt == '1) begin
                            bus.spikes       <= assembled[NUM_INPUTS-1:0];
                            bus.timestep     <= ts;
                            bus.spikes_valid <= 1'b1;
                            state            <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (bus.abort) begin
                        state            <= DONE;
                        bus.spikes_valid <= 1'b0;
                        bus.busy         <= 1'b0;
                        bus.done         <= 1'b1;
                    end else if (bus.spikes_ready) begin
                        bus.spikes_valid <= 1'b0;
                        bcnt             <= '0;
                        if (ts == last_ts && !bus.loop_en) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            ts    <= (ts == last_ts) ? '0 : ts + TS_ONE;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/spike_pattern_sequencer.md
Name: spike_pattern_sequencer

Overview:
Parametrised successor to the fixed spike-pattern memory inside the SNN core. It stores a per-timestep input spike pattern split into DATA_WIDTH-bit batches. The pattern is loaded and read back through the external-memory window (MEM_CFG batch select plus word address). During a run it plays timesteps to the first network layer over a valid/ready handshake, adding loop and abort modes that the current core lacks.

Parameters:
NUM_INPUTS, 9, number of input spike channels; must satisfy NUM_INPUTS <= DATA_WIDTH*2**BATCH_ADDR_WIDTH
DATA_WIDTH, 32, width of one batch word (AXI data width)
MAX_TIMESTEPS_BITS, 8, memory depth is 2**MAX_TIMESTEPS_BITS timesteps
BATCH_ADDR_WIDTH, 1, number of batches per timestep is 2**BATCH_ADDR_WIDTH

Ports:
clk  input  1  single clock (S_AXI_ACLK domain)
rst  input  1  synchronous active-high reset
wr_en  input  1  host write strobe
wr_batch  input  BATCH_ADDR_WIDTH  batch select for write/read
wr_addr  input  MAX_TIMESTEPS_BITS  timestep address for write/read
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  host read strobe (uses wr_batch/wr_addr)
rd_data  output  DATA_WIDTH  host read data
rd_valid  output  1  rd_data valid pulse
wr_err  output  1  pulse: host access rejected while busy
start  input  1  start playback pulse
abort  input  1  stop playback pulse
loop_en  input  1  wrap to timestep 0 after last, sampled continuously
sim_time  input  MAX_TIMESTEPS_BITS+1  timesteps to play (0..2**MAX_TIMESTEPS_BITS)
spikes  output  NUM_INPUTS  current timestep pattern
spikes_valid  output  1  spikes valid
spikes_ready  input  1  downstream accepts timestep
timestep  output  MAX_TIMESTEPS_BITS  index of presented timestep
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Memory contents are not cleared.
- Memory: synchronous RAM, 2**(MAX_TIMESTEPS_BITS+BATCH_ADDR_WIDTH) words, address {wr_addr, wr_batch}.
- Channel mapping: input n is batch n/DATA_WIDTH, bit n%DATA_WIDTH. Unused high bits of the last batch are stored but ignored.
- Host write in IDLE: committed on the wr_en cycle.
- Host read in IDLE: rd_data and rd_valid appear 1 cycle after rd_en. rd_data holds its value until the next read.
- wr_en and rd_en in the same cycle: the write takes priority, and rd_data returns the old word (read-before-write).
- Host access while busy: ignored, wr_err pulses 1 cycle later, memory unchanged.
- Effective length: eff_len = min(sim_time, 2**MAX_TIMESTEPS_BITS), latched on start.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE -> FETCH: start && eff_len != 0. busy=1 next cycle, ts=0, batch counter=0.
- IDLE -> DONE: start && eff_len == 0. No spikes_valid is ever asserted; done pulses 1 cycle after start.
- FETCH: issues one batch read per cycle, 2**BATCH_ADDR_WIDTH cycles. Assembles the pattern into a shadow register. Enters PRESENT 1 cycle after the last read issue (RAM latency).
  - Timestep-0 latency: spikes_valid rises exactly 2**BATCH_ADDR_WIDTH+1 cycles after the start cycle.
- PRESENT: spikes_valid=1, with spikes and timestep stable until spikes_valid && spikes_ready.
- On handshake, next transition:
  - If ts == eff_len-1 and loop_en=0: DONE.
  - If ts == eff_len-1 and loop_en=1: ts wraps to 0, then FETCH.
  - Otherwise: ts+1, then FETCH.
  - spikes_valid drops the cycle after the handshake.
  - Successive valid timesteps are separated by at least 2**BATCH_ADDR_WIDTH+1 cycles.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE. spikes and timestep hold their last values.
- abort in FETCH or PRESENT: next state is DONE, spikes_valid=0 next cycle, done pulses. abort in IDLE or DONE has no effect.
- start while busy: ignored.
- start and abort in the same IDLE cycle: start wins.
- loop_en deasserted mid-run: takes effect at the next end-of-pattern check.
- rst mid-run: forces IDLE next cycle, all outputs 0, no done pulse.

Test Plan:
- Load/readback: write {addr=5,batch=1}=0x0000_0155, then read it -> rd_valid 1 cycle later with rd_data=0x0000_0155. Read of an unwritten word after reset returns whatever the RAM held (not checked).
- Playback: sim_time=4, default params. Even timesteps = 0x0FA5_0FA5, odd = 0xF05A_F021, both batches. spikes_ready=1 -> spikes = 9'h1A5, 9'h021, 9'h1A5, 9'h021 at timesteps 0..3. First valid 3 cycles after start. done pulses once, busy low afterwards.
- Backpressure: spikes_ready held 0 for 10 cycles at timestep 1 -> spikes and timestep stay constant and valid stays high; the run resumes on ready.
- Boundaries:
  - sim_time=0 -> done 1 cycle after start, no valid.
  - sim_time=300 (MAX_TIMESTEPS_BITS=8, legal width 9 bits) -> clamped to 256 timesteps, last timestep=255.
- Loop and abort: loop_en=1, sim_time=3 -> timestep sequence 0,1,2,0,1. abort during the second timestep 1 -> valid low next cycle, done pulses.
- Busy protection and reset: wr_en during playback -> wr_err pulse and readback shows old data. rst mid-run -> busy=0 and spikes_valid=0 next cycle, no done.
